// File: rtl/shape_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shape_sequencer
//  Description : Steps the combinational opcode splitter through every
//                segment of one queued draw opcode (line: 1, triangle: 3,
//                circle: 1). Each segment goes to the rasterizer with a
//                draw_start/draw_done handshake. Completion is reported with
//                shape_done; an invalid shape or a segment timeout is
//                reported with err.
//  Ports       : clk, rst            - clock, async active-high reset
//                op_valid/op_ready   - opcode handshake from FIFO/decoder
//                op_shape, op_data   - shape type and 76-bit opcode
//                opdata, output_sel  - latched opcode and splitter select
//                draw_start/circle   - segment issue pulse and segment type
//                draw_done           - rasterizer segment completion pulse
//                shape_done, err     - opcode completion / error pulses
//                busy                - sequencer is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module shape_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TW             = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_shape,
    input  logic [75:0] op_data,
    output logic [75:0] opdata,
    output logic [3:0]  output_sel,
    output logic        draw_start,
    output logic        draw_circle,
    input  logic        draw_done,
    output logic        shape_done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]    c_SHAPE_LINE   = 2'd0;
    localparam logic [1:0]    c_SHAPE_TRI    = 2'd1;
    localparam logic [1:0]    c_SHAPE_CIRCLE = 2'd2;
    localparam logic [1:0]    c_SHAPE_BAD    = 2'd3;
    localparam logic [3:0]    c_SEL_L1       = 4'd0;
    localparam logic [3:0]    c_SEL_TRI1     = 4'd1;
    localparam logic [3:0]    c_SEL_TRI3     = 4'd3;
    localparam logic [3:0]    c_SEL_CIR1     = 4'd4;
    localparam logic [TW-1:0] c_TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [1:0]    r_shape;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_next;
    logic [TW-1:0] w_cnt_inc;
    logic [3:0]    w_sel_next;
    logic          w_accept;
    logic          w_draw_start_next;
    logic          w_draw_circle_next;
    logic          w_shape_done_next;
    logic          w_err_next;

    assign op_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign w_cnt_inc = r_cnt + 1'b1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-output decode. Outputs are computed one cycle
    // ahead so that every pulse leaves the block straight from a flop.
    always_comb begin
        w_next_state       = r_state;
        w_accept           = 1'b0;
        w_cnt_next         = r_cnt;
        w_sel_next         = output_sel;
        w_draw_start_next  = 1'b0;
        w_draw_circle_next = 1'b0;
        w_shape_done_next  = 1'b0;
        w_err_next         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
                    if (op_shape == c_SHAPE_BAD) begin
                        // Rejected opcode: report it but keep the splitter
                        // inputs untouched.
                        w_err_next = 1'b1;
                    end else begin
                        w_accept           = 1'b1;
                        w_next_state       = S_ISSUE;
                        w_draw_start_next  = 1'b1;
                        w_draw_circle_next = (op_shape == c_SHAPE_CIRCLE);
                        case (op_shape)
                            c_SHAPE_LINE: w_sel_next = c_SEL_L1;
                            c_SHAPE_TRI:  w_sel_next = c_SEL_TRI1;
                            default:      w_sel_next = c_SEL_CIR1;
                        endcase
                    end
                end
            end

            S_ISSUE: begin
                w_cnt_next   = '0;
                w_next_state = S_WAIT;
            end

            S_WAIT: begin
                w_cnt_next = w_cnt_inc;
                // draw_done takes priority over a coincident timeout.
                if (draw_done) begin
                    if ((r_shape == c_SHAPE_TRI) && (output_sel < c_SEL_TRI3)) begin
                        w_sel_next        = output_sel + 4'd1;
                        w_next_state      = S_ISSUE;
                        w_draw_start_next = 1'b1;
                    end else begin
                        w_next_state      = S_DONE;
                        w_shape_done_next = 1'b1;
                    end
                end else if (w_cnt_inc == c_TIMEOUT_LAST) begin
                    w_err_next   = 1'b1;
                    w_sel_next   = c_SEL_L1;
                    w_next_state = S_IDLE;
                end
            end

            S_DONE: begin
                w_sel_next   = c_SEL_L1;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opdata      <= '0;
            r_shape     <= c_SHAPE_LINE;
            r_cnt       <= '0;
            output_sel  <= c_SEL_L1;
            draw_start  <= 1'b0;
            draw_circle <= 1'b0;
            shape_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (w_accept) begin
                opdata  <= op_data;
                r_shape <= op_shape;
            end
            r_cnt       <= w_cnt_next;
            output_sel  <= w_sel_next;
            draw_start  <= w_draw_start_next;
            draw_circle <= w_draw_circle_next;
            shape_done  <= w_shape_done_next;
            err         <= w_err_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shape_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shape_sequencer
//  Description : Directed self-checking bench for shape_sequencer (built with
//                an 8-cycle segment timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shape_sequencer;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_shape;
    logic [75:0] op_data;
    logic [75:0] opdata;
    logic [3:0]  output_sel;
    logic        draw_start;
    logic        draw_circle;
    logic        draw_done;
    logic        shape_done;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitors (sampled on the falling edge)
    int         n_start = 0;
    int         n_sdone = 0;
    int         n_err   = 0;
    logic [3:0] start_sel [0:63];

    shape_sequencer #(
        .TIMEOUT_CYCLES (8),
        .TW             (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_shape    (op_shape),
        .op_data     (op_data),
        .opdata      (opdata),
        .output_sel  (output_sel),
        .draw_start  (draw_start),
        .draw_circle (draw_circle),
        .draw_done   (draw_done),
        .shape_done  (shape_done),
        .err         (err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (draw_start) begin
                if (n_start < 64) start_sel[n_start] = output_sel;
                n_start = n_start + 1;
            end
            if (shape_done) n_sdone = n_sdone + 1;
            if (err)        n_err   = n_err + 1;
        end
    end

    task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " op_ready"},    op_ready,    1'b1);
        check({tag, " busy"},        busy,        1'b0);
        check({tag, " opdata"},      opdata,      76'h0);
        check({tag, " output_sel"},  output_sel,  4'd0);
        check({tag, " draw_start"},  draw_start,  1'b0);
        check({tag, " draw_circle"}, draw_circle, 1'b0);
        check({tag, " shape_done"},  shape_done,  1'b0);
        check({tag, " err"},         err,         1'b0);
    endtask

    logic [75:0] line_data;
    logic [75:0] tri_data;
    logic [75:0] cir_data;
    int          s_base;
    int          d_base;
    int          e_base;

    initial begin
        rst       = 1'b0;
        op_valid  = 1'b0;
        op_shape  = 2'd0;
        op_data   = '0;
        draw_done = 1'b0;
        line_data = {19'h1ABCD, 19'h00123, 19'h00000, 1'b0, 18'h00000};
        tri_data  = {19'h01111, 19'h02222, 19'h03333, 1'b1, 18'h00000};
        cir_data  = {19'h05555, 19'h00040, 19'h00000, 1'b0, 18'h00000};

        // ---------------- Asynchronous reset between edges ----------------
        #12 rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // ---------------- Line ----------------
        s_base = n_start; d_base = n_sdone;
        op_valid = 1'b1; op_shape = 2'd0; op_data = line_data;
        tick();                                    // ISSUE cycle S
        op_valid = 1'b0; op_data = '0;
        check("line draw_start",  draw_start,  1'b1);
        check("line sel",         output_sel,  4'd0);
        check("line draw_circle", draw_circle, 1'b0);
        check("line op_ready",    op_ready,    1'b0);
        check("line loc1",        opdata[75:57], 19'h1ABCD);
        check("line loc2",        opdata[56:38], 19'h00123);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("line wait no start", draw_start, 1'b0);
        end
        tick();                                    // S+5
        draw_done = 1'b1;
        tick();                                    // DONE
        draw_done = 1'b0;
        check("line shape_done", shape_done, 1'b1);
        tick();                                    // back in IDLE
        check("line idle op_ready",   op_ready,   1'b1);
        check("line idle shape_done", shape_done, 1'b0);
        check("line opdata held",     opdata,     line_data);
        check("line start count",     n_start - s_base, 1);
        check("line sdone count",     n_sdone - d_base, 1);

        // ---------------- Triangle ----------------
        s_base = n_start; d_base = n_sdone;
        op_valid = 1'b1; op_shape = 2'd1; op_data = tri_data;
        tick();                                    // first ISSUE
        op_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("tri draw_start", draw_start, 1'b1);
            check("tri sel",        output_sel, 4'(k + 1));
            check("tri op_ready",   op_ready,   1'b0);
            tick();
            check("tri op_ready wait", op_ready, 1'b0);
            tick();
            draw_done = 1'b1;
            tick();
            draw_done = 1'b0;
        end
        check("tri shape_done",    shape_done, 1'b1);
        check("tri op_ready done", op_ready,   1'b0);
        tick();
        check("tri idle op_ready", op_ready, 1'b1);
        check("tri start count",   n_start - s_base, 3);
        check("tri sel log 1",     start_sel[s_base],     4'd1);
        check("tri sel log 2",     start_sel[s_base + 1], 4'd2);
        check("tri sel log 3",     start_sel[s_base + 2], 4'd3);
        check("tri sdone count",   n_sdone - d_base, 1);

        // ---------------- Circle then invalid ----------------
        s_base = n_start; d_base = n_sdone; e_base = n_err;
        op_valid = 1'b1; op_shape = 2'd2; op_data = cir_data;
        tick();
        op_valid = 1'b0;
        check("cir draw_start",  draw_start,  1'b1);
        check("cir draw_circle", draw_circle, 1'b1);
        check("cir sel",         output_sel,  4'd4);
        tick();
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        check("cir shape_done", shape_done, 1'b1);
        tick();
        check("cir idle sel", output_sel, 4'd0);
        check("cir start count", n_start - s_base, 1);
        s_base = n_start;
        op_valid = 1'b1; op_shape = 2'd3; op_data = {76{1'b1}};
        tick();
        op_valid = 1'b0; op_data = '0;
        check("bad err",        err,        1'b1);
        check("bad busy",       busy,       1'b0);
        check("bad draw_start", draw_start, 1'b0);
        check("bad opdata",     opdata,     cir_data);
        check("bad sel",        output_sel, 4'd0);
        tick();
        check("bad err cleared", err,  1'b0);
        check("bad busy after",  busy, 1'b0);
        check("bad err count",   n_err - e_base, 1);
        check("bad no start",    n_start - s_base, 0);

        // ---------------- Timeout (8 cycles) ----------------
        d_base = n_sdone; e_base = n_err;
        op_valid = 1'b1; op_shape = 2'd1; op_data = tri_data;
        tick();                                    // ISSUE cycle S
        op_valid = 1'b0;
        check("to draw_start", draw_start, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("to no err yet", err,  1'b0);
            check("to busy",       busy, 1'b1);
        end
        tick();                                    // S+8
        check("to err",      err,        1'b1);
        check("to sel",      output_sel, 4'd0);
        check("to idle",     op_ready,   1'b1);
        tick();
        check("to err once",  n_err - e_base,   1);
        check("to no sdone",  n_sdone - d_base, 0);

        // ---------------- Reset mid-triangle ----------------
        d_base = n_sdone; e_base = n_err;
        op_valid = 1'b1; op_shape = 2'd1; op_data = tri_data;
        tick();                                    // ISSUE sel 1
        op_valid = 1'b0;
        tick();                                    // WAIT
        draw_done = 1'b1;
        tick();                                    // ISSUE sel 2
        draw_done = 1'b0;
        check("mid sel 2", output_sel, 4'd2);
        tick();                                    // WAIT of second edge
        check("mid busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("mid reset");
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("mid no sdone", n_sdone - d_base, 0);
        check("mid no err",   n_err - e_base,   0);

        s_base = n_start; d_base = n_sdone;
        op_valid = 1'b1; op_shape = 2'd0; op_data = line_data;
        tick();
        op_valid = 1'b0;
        check("post draw_start", draw_start, 1'b1);
        check("post sel",        output_sel, 4'd0);
        tick();
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        check("post shape_done", shape_done, 1'b1);
        tick();
        check("post idle",       op_ready,   1'b1);
        check("post counts",     n_sdone - d_base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
